// File: rtl/ntt_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared constants and types for the NTT layer scheduler:
//   N, NUM_LAYERS, NUM_PAIRS  - transform geometry (256 points, 7 layers,
//                               128 butterflies per layer)
//   BF_MODE_*                 - butterfly mode encodings driven on bf_mode
//   state_t                   - scheduler FSM state encoding
// ---------------------------------------------------------------------------
package ntt_pkg;

   localparam int N          = 256;
   localparam int NUM_LAYERS = 7;
   localparam int NUM_PAIRS  = 128;

   localparam logic [1:0] BF_MODE_NTT  = 2'b00;
   localparam logic [1:0] BF_MODE_INTT = 2'b01;
   localparam logic [1:0] BF_MODE_IDLE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// ---------------------------------------------------------------------------
// ntt_addr_gen
// Combinational address generator for one butterfly pair.
//   s       in  3  layer index 0..6
//   p       in  7  pair index within the layer 0..127
//   inv     in  1  0 = forward (len shrinks), 1 = inverse (len grows)
//   addr_a  out 8  coefficient address of the upper operand
//   addr_b  out 8  coefficient address of the lower operand (addr_a + len)
//   z_addr  out 7  zeta ROM index
// ---------------------------------------------------------------------------
module ntt_addr_gen
   import ntt_pkg::*;
(
   input  logic [2:0] s,
   input  logic [6:0] p,
   input  logic       inv,
   output logic [7:0] addr_a,
   output logic [7:0] addr_b,
   output logic [6:0] z_addr
);

   logic [3:0] lg;     // log2(len), 1..7
   logic [7:0] len;
   logic [6:0] g;      // butterfly group
   logic [6:0] o;      // offset inside the group
   logic [6:0] mask;

   always_comb begin
      lg   = inv ? ({1'b0, s} + 4'd1) : (4'd7 - {1'b0, s});
      len  = 8'd1 << lg;
      mask = ~(7'h7f << lg);
      g    = p >> lg;
      o    = p & mask;
      // 2*len*g is a shift by lg+1; group base and offset never overlap
      addr_a = ({1'b0, g} << (lg + 4'd1)) | {1'b0, o};
      addr_b = addr_a + len;
      // forward walks zetas upward from 1<<s; inverse walks down from
      // (128>>s)-1, and 7'h7f>>s is exactly that start point
      z_addr = inv ? ((7'h7f >> s) - g) : ((7'd1 << s) + g);
   end

endmodule

// File: rtl/ntt_sched.sv
// ---------------------------------------------------------------------------
// ntt_sched
// In-place NTT / inverse NTT scheduler for a 256-point transform. Issues one
// butterfly pair per cycle over 7 layers, forwards RAM/ROM read data straight
// to an external butterfly, and writes results back through a delay line that
// tracks the read-to-result latency D = RD_LAT + BF_LAT.
//   clk, rst                  clock, asynchronous active-high reset
//   start, inv                request and direction (inv sampled with start)
//   busy, done                operation in progress / one-cycle completion
//   rd_en, rd_addr_a/b        coefficient RAM read pair
//   rd_data_a/b               read data, RD_LAT cycles after rd_en
//   z_addr, z_data            zeta ROM address (with rd_en) and data
//   bf_a/b/w, bf_mode         butterfly operands and mode
//   bf_c/d                    butterfly results, BF_LAT after operands
//   wr_en, wr_addr_a/b,
//   wr_data_a/b               coefficient RAM write-back pair
// ---------------------------------------------------------------------------
module ntt_sched
   import ntt_pkg::*;
#(
   parameter int BF_LAT = 4,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        inv,
   output logic        busy,
   output logic        done,
   output logic        rd_en,
   output logic [7:0]  rd_addr_a,
   output logic [7:0]  rd_addr_b,
   input  logic [15:0] rd_data_a,
   input  logic [15:0] rd_data_b,
   output logic [6:0]  z_addr,
   input  logic [15:0] z_data,
   output logic [15:0] bf_a,
   output logic [15:0] bf_b,
   output logic [15:0] bf_w,
   output logic [1:0]  bf_mode,
   input  logic [15:0] bf_c,
   input  logic [15:0] bf_d,
   output logic        wr_en,
   output logic [7:0]  wr_addr_a,
   output logic [7:0]  wr_addr_b,
   output logic [15:0] wr_data_a,
   output logic [15:0] wr_data_b
);

   localparam int         D          = RD_LAT + BF_LAT;
   localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
   localparam logic [6:0] LAST_PAIR  = 7'(NUM_PAIRS - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(D - 1);

   state_t      state, state_nxt;
   logic [2:0]  layer;
   logic [6:0]  pair;
   logic [7:0]  drain_cnt;
   logic        inv_q;
   logic        drain_last;

   logic [7:0]  gen_a, gen_b;
   logic [6:0]  gen_z;

   // write-back delay line: stage i holds the pair issued i+1 cycles ago
   logic        vld_p    [D];
   logic [7:0]  addr_a_p [D];
   logic [7:0]  addr_b_p [D];

   ntt_addr_gen u_addr_gen (
      .s      (layer),
      .p      (pair),
      .inv    (inv_q),
      .addr_a (gen_a),
      .addr_b (gen_b),
      .z_addr (gen_z)
   );

   assign drain_last = (drain_cnt == DRAIN_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            rd_en = 1'b1;
            if (pair == LAST_PAIR) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drain_last) state_nxt = (layer == LAST_LAYER) ? ST_IDLE : ST_ISSUE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         layer     <= '0;
         pair      <= '0;
         drain_cnt <= '0;
         inv_q     <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= (state == ST_DRAIN) && drain_last && (layer == LAST_LAYER);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  inv_q     <= inv;
                  layer     <= '0;
                  pair      <= '0;
                  drain_cnt <= '0;
               end
            end
            ST_ISSUE: begin
               pair <= pair + 7'd1;   // wraps to 0 after the last pair
            end
            ST_DRAIN: begin
               if (drain_last) begin
                  drain_cnt <= '0;
                  layer     <= (layer == LAST_LAYER) ? 3'd0 : layer + 3'd1;
               end else begin
                  drain_cnt <= drain_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- issue stage -> write-back stage (D cycles) ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < D; i++) begin
            vld_p[i]    <= 1'b0;
            addr_a_p[i] <= '0;
            addr_b_p[i] <= '0;
         end
      end else begin
         vld_p[0]    <= rd_en;
         addr_a_p[0] <= rd_addr_a;
         addr_b_p[0] <= rd_addr_b;
         for (int i = 1; i < D; i++) begin
            vld_p[i]    <= vld_p[i-1];
            addr_a_p[i] <= addr_a_p[i-1];
            addr_b_p[i] <= addr_b_p[i-1];
         end
      end
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      bf_mode   = busy ? (inv_q ? BF_MODE_INTT : BF_MODE_NTT) : BF_MODE_IDLE;
      // addresses forced to 0 whenever no read is issued
      rd_addr_a = rd_en ? gen_a : 8'd0;
      rd_addr_b = rd_en ? gen_b : 8'd0;
      z_addr    = rd_en ? gen_z : 7'd0;
      // operands pass straight through; zeroed only while reset is held
      bf_a      = rst ? 16'd0 : rd_data_a;
      bf_b      = rst ? 16'd0 : rd_data_b;
      bf_w      = rst ? 16'd0 : z_data;
      wr_en     = vld_p[D-1];
      wr_addr_a = addr_a_p[D-1];
      wr_addr_b = addr_b_p[D-1];
      wr_data_a = wr_en ? bf_c : 16'd0;
      wr_data_b = wr_en ? bf_d : 16'd0;
   end

endmodule

// File: tb/tb_ntt_sched.sv
// ---------------------------------------------------------------------------
// tb_ntt_sched
// Bench for ntt_sched: coefficient RAM, zeta ROM and a modular butterfly are
// modelled around the DUT; a loop-structured NTT/INTT reference predicts the
// read/write address stream and the final RAM contents.
// ---------------------------------------------------------------------------
module tb_ntt_sched;

   localparam int BF_LAT = 4;
   localparam int RD_LAT = 1;
   localparam int D      = RD_LAT + BF_LAT;
   localparam int Q      = 3329;
   localparam int OPS    = 896;
   localparam int DONE_AT = 932;

   logic        clk = 1'b0;
   logic        rst, start, inv;
   logic        busy, done, rd_en, wr_en;
   logic [7:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [6:0]  z_addr;
   logic [15:0] rd_data_a = '0, rd_data_b = '0, z_data = '0;
   logic [15:0] bf_a, bf_b, bf_w, bf_c, bf_d, wr_data_a, wr_data_b;
   logic [1:0]  bf_mode;

   logic [15:0] ram      [256];
   logic [15:0] init_mem [256];
   logic [15:0] zrom     [128];
   logic        ld = 1'b0;
   logic [31:0] bf_pipe  [BF_LAT];

   int mdl [256];
   int exp_a[$], exp_b[$], exp_z[$];
   int n_total = 0, n_bad = 0;

   always #5 clk = ~clk;

   ntt_sched #(.BF_LAT(BF_LAT), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .inv(inv), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .z_addr(z_addr), .z_data(z_data),
      .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_mode(bf_mode),
      .bf_c(bf_c), .bf_d(bf_d),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
   );

   // modular butterfly: forward c=a+wb, d=a-wb; inverse c=a+b, d=w(b-a)
   function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] w, input logic [1:0] m);
      int ai, bi, wi, c, d, t;
      ai = int'(a) % Q; bi = int'(b) % Q; wi = int'(w) % Q;
      if (m == 2'b01) begin
         c = (ai + bi) % Q;
         d = (wi * ((bi - ai + Q) % Q)) % Q;
      end else begin
         t = (wi * bi) % Q;
         c = (ai + t) % Q;
         d = (ai - t + Q) % Q;
      end
      return {16'(d), 16'(c)};
   endfunction

   always @(posedge clk) begin
      bf_pipe[0] <= bfly(bf_a, bf_b, bf_w, bf_mode);
      for (int i = 1; i < BF_LAT; i++) bf_pipe[i] <= bf_pipe[i-1];
   end
   assign bf_c = bf_pipe[BF_LAT-1][15:0];
   assign bf_d = bf_pipe[BF_LAT-1][31:16];

   always @(posedge clk) begin
      if (ld) begin
         for (int i = 0; i < 256; i++) ram[i] <= init_mem[i];
      end else if (wr_en) begin
         ram[wr_addr_a] <= wr_data_a;
         ram[wr_addr_b] <= wr_data_b;
      end
      if (rd_en) begin
         rd_data_a <= ram[rd_addr_a];
         rd_data_b <= ram[rd_addr_b];
         z_data    <= zrom[z_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_total++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic int brv7(input int k);
      int r = 0;
      for (int i = 0; i < 7; i++) if (k[i]) r |= (1 << (6 - i));
      return r;
   endfunction

   function automatic int pow17(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = (r * 17) % Q;
      return r;
   endfunction

   // Kyber-style nested loops over (len, start, j); records the pair order
   task automatic ref_run(input bit iv);
      int k, w, t;
      exp_a.delete(); exp_b.delete(); exp_z.delete();
      if (!iv) begin
         k = 1;
         for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               w = int'(zrom[k]);
               for (int j = st; j < st + len; j++) begin
                  exp_a.push_back(j); exp_b.push_back(j + len); exp_z.push_back(k);
                  t = (w * mdl[j+len]) % Q;
                  mdl[j+len] = (mdl[j] - t + Q) % Q;
                  mdl[j]     = (mdl[j] + t) % Q;
               end
               k++;
            end
      end else begin
         k = 127;
         for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st += 2 * len) begin
               w = int'(zrom[k]);
               for (int j = st; j < st + len; j++) begin
                  exp_a.push_back(j); exp_b.push_back(j + len); exp_z.push_back(k);
                  t = mdl[j];
                  mdl[j]     = (t + mdl[j+len]) % Q;
                  mdl[j+len] = (w * ((mdl[j+len] - t + Q) % Q)) % Q;
               end
               k--;
            end
      end
   endtask

   task automatic run_op(input bit iv, input int dup_at, input int rst_at);
      int nrd = 0, nwr = 0, ndone = 0, done_cyc = -1;
      int bad_rd = 0, bad_wr = 0, bad_busy = 0, bad_mode = 0, bad_gap = 0, bad_once = 0;
      int mism = 0, quiet = 0;
      int firstr [7];
      int lastw  [7];
      int rd_cyc [OPS];
      int wcnt   [7][256];
      logic        exp_busy;
      logic [22:0] snap0 = '0, snap768 = '0, snap895 = '0, cur;

      for (int l = 0; l < 7; l++) begin
         firstr[l] = -1; lastw[l] = -1;
         for (int a = 0; a < 256; a++) wcnt[l][a] = 0;
      end
      for (int i = 0; i < 256; i++) begin
         init_mem[i] = 16'($urandom_range(Q - 1));
         mdl[i]      = int'(init_mem[i]);
      end
      ref_run(iv);
      @(negedge clk); ld = 1'b1;
      @(negedge clk); ld = 1'b0; start = 1'b1; inv = iv;

      for (int c = 1; c <= DONE_AT + 20; c++) begin
         @(negedge clk);
         if (c == 1) begin start = 1'b0; inv = ~iv; end
         if (c == dup_at) begin start = 1'b1; inv = ~iv; end
         if (c == dup_at + 1) start = 1'b0;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_ctrl", {busy, done, rd_en, wr_en, bf_mode}, 6'b000011);
            check("rst_rd_addr", {rd_addr_a, rd_addr_b, z_addr}, 0);
            check("rst_wr", {wr_addr_a, wr_addr_b, wr_data_a, wr_data_b}, 0);
            check("rst_bf", {bf_a, bf_b, bf_w}, 0);
            @(negedge clk); rst = 1'b0;
            repeat (20) begin
               @(negedge clk);
               if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) quiet++;
            end
            check("post_rst_quiet", quiet, 0);
            return;
         end

         exp_busy = (c < DONE_AT);
         if (busy !== exp_busy) bad_busy++;
         if (bf_mode !== (exp_busy ? {1'b0, iv} : 2'b11)) bad_mode++;
         if (done === 1'b1) begin ndone++; done_cyc = c; end
         if (rd_en === 1'b1) begin
            if (nrd < OPS) begin
               if (rd_addr_a !== 8'(exp_a[nrd]) || rd_addr_b !== 8'(exp_b[nrd]) ||
                   z_addr !== 7'(exp_z[nrd])) bad_rd++;
               if (nrd % 128 == 0) firstr[nrd / 128] = c;
               rd_cyc[nrd] = c;
               cur = {rd_addr_a, rd_addr_b, z_addr};
               if (nrd == 0)   snap0   = cur;
               if (nrd == 768) snap768 = cur;
               if (nrd == 895) snap895 = cur;
            end else bad_rd++;
            nrd++;
         end
         if (wr_en === 1'b1) begin
            if (nwr < nrd && nwr < OPS) begin
               if (wr_addr_a !== 8'(exp_a[nwr]) || wr_addr_b !== 8'(exp_b[nwr])) bad_wr++;
               if (c != rd_cyc[nwr] + D) bad_wr++;
               lastw[nwr / 128] = c;
               wcnt[nwr / 128][wr_addr_a]++;
               wcnt[nwr / 128][wr_addr_b]++;
            end else bad_wr++;
            nwr++;
         end
      end

      for (int l = 0; l < 6; l++) if (firstr[l+1] != lastw[l] + 1) bad_gap++;
      for (int l = 0; l < 7; l++)
         for (int a = 0; a < 256; a++) if (wcnt[l][a] != 1) bad_once++;
      for (int i = 0; i < 256; i++) if (int'(ram[i]) != mdl[i]) mism++;

      check("rd_count", nrd, OPS);
      check("wr_count", nwr, OPS);
      check("rd_addr_errs", bad_rd, 0);
      check("wr_addr_errs", bad_wr, 0);
      check("busy_errs", bad_busy, 0);
      check("mode_errs", bad_mode, 0);
      check("done_count", ndone, 1);
      check("done_cycle", done_cyc, DONE_AT);
      check("layer_gap_errs", bad_gap, 0);
      check("write_once_errs", bad_once, 0);
      check("ram_result_errs", mism, 0);
      if (!iv) begin
         check("ntt_first_rd", snap0, {8'd0, 8'd128, 7'd1});
         check("ntt_last_rd", snap895, {8'd253, 8'd255, 7'd127});
      end else begin
         check("intt_first_rd", snap0, {8'd0, 8'd2, 7'd127});
         check("intt_l6p0_rd", snap768, {8'd0, 8'd128, 7'd1});
      end
   endtask

   initial begin
      for (int k = 0; k < 128; k++) zrom[k] = 16'(pow17(brv7(k)));
      rst = 1'b1; start = 1'b0; inv = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", {busy, done, rd_en, wr_en, bf_mode}, 6'b000011);
      check("reset_addr", {rd_addr_a, rd_addr_b, z_addr, wr_addr_a, wr_addr_b}, 0);
      rst = 1'b0;
      @(negedge clk);

      run_op(1'b0, 0, 0);
      run_op(1'b1, 0, 0);
      run_op(1'b0, 50, 0);
      run_op(1'b1, 50, 0);
      run_op(1'b0, 0, 300);
      run_op(1'b0, 0, 0);
      run_op(1'($urandom_range(1)), 0, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
